// File: rtl/apb_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_pkg
//  Purpose  : Shared types and constants for the APB4 master controller.
//  Revision : 1.0  initial release
// ============================================================================
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSP_OKAY    = 2'b00,
        RSP_SLVERR  = 2'b01,
        RSP_TIMEOUT = 2'b10,
        RSP_DECERR  = 2'b11
    } rsp_err_t;

    localparam int ERR_CNT_W = 16;

    // A single slave still needs a 1-bit index vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_ctrl_if
//  Purpose  : Request/response channel plus APB4 bus bundle for the master.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_master_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int PPROT_WIDTH = 3,
    parameter int NUM_SLAVES  = 4
);
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_write;
    logic [ADDR_WIDTH-1:0]          req_addr;
    logic [DATA_WIDTH-1:0]          req_wdata;
    logic [DATA_WIDTH/8-1:0]        req_strb;
    logic [PPROT_WIDTH-1:0]         req_prot;

    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [DATA_WIDTH-1:0]          rsp_rdata;
    logic [1:0]                     rsp_err;

    logic [ADDR_WIDTH-1:0]          m_apb_paddr;
    logic                           m_apb_pwrite;
    logic [DATA_WIDTH-1:0]          m_apb_pwdata;
    logic [DATA_WIDTH/8-1:0]        m_apb_pstrb;
    logic [PPROT_WIDTH-1:0]         m_apb_pprot;
    logic [NUM_SLAVES-1:0]          m_apb_psel;
    logic                           m_apb_penable;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] m_apb_prdata;
    logic [NUM_SLAVES-1:0]          m_apb_pready;
    logic [NUM_SLAVES-1:0]          m_apb_pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output m_apb_paddr, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
        output m_apb_psel, m_apb_penable,
        input  m_apb_prdata, m_apb_pready, m_apb_pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  m_apb_paddr, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
        input  m_apb_psel, m_apb_penable,
        output m_apb_prdata, m_apb_pready, m_apb_pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_ctrl_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : apb_addr_decode
//  Purpose  : Byte address to slave index, one-hot select and decode error.
//  Revision : 1.0  initial release
// ============================================================================
module apb_addr_decode
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12
) (
    input  wire logic [ADDR_WIDTH-1:0]                addr,
    output logic      [idx_width(NUM_SLAVES)-1:0]     idx,
    output logic      [NUM_SLAVES-1:0]                sel,
    output logic                                      dec_err
);
    localparam int c_IDX_W = idx_width(NUM_SLAVES);

    logic w_unused_addr;
    assign w_unused_addr = ^addr;

    generate
        if (NUM_SLAVES == 1) begin : g_single
            assign idx     = '0;
            assign sel     = 1'b1;
            assign dec_err = 1'b0;
        end else begin : g_multi
            localparam logic [c_IDX_W:0] c_NUM = (c_IDX_W+1)'(NUM_SLAVES);

            assign idx     = addr[SEL_LSB +: c_IDX_W];
            // Non-power-of-two slave counts leave unused index codes.
            assign dec_err = ({1'b0, idx} >= c_NUM);

            always_comb begin
                sel = '0;
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    sel[i] = (idx == c_IDX_W'(i));
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_ctrl
//  Purpose  : APB4 master bridging a valid/ready request channel to NUM_SLAVES
//             peripherals, with decode error, PSLVERR and wait-state timeout.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PPROT_WIDTH    = 3,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    apb_master_ctrl_if.master         bus,
    output logic [ERR_CNT_W-1:0]      err_count
);
    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_IDX_W  = idx_width(NUM_SLAVES);
    localparam int c_TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);
    localparam bit   c_TO_EN    = (TIMEOUT_CYCLES > 0);

    state_t                   r_state, w_state_nx;

    logic [ADDR_WIDTH-1:0]    r_paddr;
    logic                     r_pwrite;
    logic [DATA_WIDTH-1:0]    r_pwdata;
    logic [c_STRB_W-1:0]      r_pstrb;
    logic [PPROT_WIDTH-1:0]   r_pprot;
    logic [NUM_SLAVES-1:0]    r_sel;
    logic [c_TO_W-1:0]        r_to_cnt;
    logic [DATA_WIDTH-1:0]    r_rsp_rdata;
    rsp_err_t                 r_rsp_err;
    logic [ERR_CNT_W-1:0]     r_err_count;

    logic [c_IDX_W-1:0]       w_dec_idx;
    logic [NUM_SLAVES-1:0]    w_dec_sel;
    logic                     w_dec_err;
    logic [DATA_WIDTH-1:0]    w_prdata;
    logic                     w_pready;
    logic                     w_pslverr;
    logic                     w_timeout;
    logic                     w_req_hs;
    logic                     w_load_rsp;
    rsp_err_t                 w_rsp_err_d;
    logic [DATA_WIDTH-1:0]    w_rsp_rdata_d;
    logic                     w_unused_idx;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB)
    ) u_decode (
        .addr    (bus.req_addr),
        .idx     (w_dec_idx),
        .sel     (w_dec_sel),
        .dec_err (w_dec_err)
    );

    assign w_unused_idx = ^w_dec_idx;

    // Only the registered one-hot select can contribute, so other slaves are ignored.
    always_comb begin
        w_prdata  = '0;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_prdata  = w_prdata  | (bus.m_apb_prdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_sel[i]}});
            w_pready  = w_pready  | (bus.m_apb_pready[i]  & r_sel[i]);
            w_pslverr = w_pslverr | (bus.m_apb_pslverr[i] & r_sel[i]);
        end
    end

    assign w_timeout = c_TO_EN && ((r_to_cnt + c_TO_W'(1)) == c_TO_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx    = r_state;
        w_req_hs      = 1'b0;
        w_load_rsp    = 1'b0;
        w_rsp_err_d   = RSP_OKAY;
        w_rsp_rdata_d = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_req_hs = 1'b1;
                    if (w_dec_err) begin
                        w_state_nx  = ST_RESP;
                        w_load_rsp  = 1'b1;
                        w_rsp_err_d = RSP_DECERR;
                    end else begin
                        w_state_nx  = ST_SETUP;
                    end
                end
            end
            ST_SETUP: w_state_nx = ST_ACCESS;
            ST_ACCESS: begin
                // A pready coinciding with the timeout completes normally.
                if (w_pready) begin
                    w_state_nx = ST_RESP;
                    w_load_rsp = 1'b1;
                    if (w_pslverr) begin
                        w_rsp_err_d = RSP_SLVERR;
                    end else begin
                        w_rsp_err_d   = RSP_OKAY;
                        w_rsp_rdata_d = r_pwrite ? '0 : w_prdata;
                    end
                end else if (w_timeout) begin
                    w_state_nx  = ST_RESP;
                    w_load_rsp  = 1'b1;
                    w_rsp_err_d = RSP_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
            r_sel       <= '0;
            r_to_cnt    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= RSP_OKAY;
            r_err_count <= '0;
        end else begin
            if (w_req_hs) begin
                r_paddr  <= bus.req_addr;
                r_pwrite <= bus.req_write;
                r_pprot  <= bus.req_prot;
                r_pstrb  <= bus.req_write ? bus.req_strb : '0;
                r_sel    <= w_dec_sel;
                if (bus.req_write) r_pwdata <= bus.req_wdata;
            end
            if (r_state == ST_SETUP)       r_to_cnt <= '0;
            else if (r_state == ST_ACCESS) r_to_cnt <= r_to_cnt + c_TO_W'(1);
            if (w_load_rsp) begin
                r_rsp_rdata <= w_rsp_rdata_d;
                r_rsp_err   <= w_rsp_err_d;
                if ((w_rsp_err_d != RSP_OKAY) && (r_err_count != '1))
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.req_ready     = (r_state == ST_IDLE) && !reset;
    assign bus.rsp_valid     = (r_state == ST_RESP);
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.m_apb_paddr   = r_paddr;
    assign bus.m_apb_pwrite  = r_pwrite;
    assign bus.m_apb_pwdata  = r_pwdata;
    assign bus.m_apb_pstrb   = r_pstrb;
    assign bus.m_apb_pprot   = r_pprot;
    assign bus.m_apb_psel    = ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) ? r_sel : '0;
    assign bus.m_apb_penable = (r_state == ST_ACCESS);
    assign err_count         = r_err_count;

endmodule
`default_nettype wire

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Synthesizable, parametrised APB4 master that turns a valid/ready request channel into APB SETUP/ACCESS transfers. It drives NUM_SLAVES peripherals with per-slave PSEL, and returns read data and a response code on a valid/ready response channel. It adds address decode, PSLVERR reporting, wait-state timeout and an error counter. It sits between the DMA/CPU-side request logic and the peripheral APB fabric, replacing the testbench-only APB driver task on FPGA builds.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, data width; multiple of 8
- PPROT_WIDTH, 3, PPROT width
- NUM_SLAVES, 4, number of PSEL lines; 1..16
- SEL_LSB, 12, lowest address bit of the slave index field
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write strobes
- req_prot  in  PPROT_WIDTH  protection attributes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  2  00 OKAY, 01 SLVERR, 10 TIMEOUT, 11 DECERR
- err_count  out  16  saturating count of non-OKAY responses
- m_apb_paddr / m_apb_pwrite / m_apb_pwdata / m_apb_pstrb / m_apb_pprot  out  per parameters  APB address/control/data
- m_apb_psel  out  NUM_SLAVES  one-hot select
- m_apb_penable  out  1  ACCESS phase
- m_apb_prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- m_apb_pready, m_apb_pslverr  in  NUM_SLAVES  per-slave ready and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - req_ready=1 only in IDLE.
  - On handshake, register the address, write flag, wdata, strb and prot.
  - Slave index = req_addr[SEL_LSB +: $clog2(NUM_SLAVES)], or 0 when NUM_SLAVES=1.
  - Index ≥ NUM_SLAVES: skip the bus and go to RESP with DECERR.
  - Otherwise go to SETUP.
- **SETUP:** psel[idx]=1, penable=0. Always go to ACCESS.
- **ACCESS:**
  - penable=1 and the selected psel stays 1.
  - When the selected pready is sampled 1:
    - capture prdata[idx] for reads (0 for writes);
    - rsp_err = pslverr[idx] ? SLVERR : OKAY, with rdata forced to 0 on SLVERR;
    - go to RESP.
  - The timeout counter counts ACCESS cycles. When it reaches TIMEOUT_CYCLES without pready, abort with TIMEOUT and rdata 0.
- **RESP:** rsp_valid=1 with stable rdata and err. Return to IDLE when rsp_ready=1.
- pstrb is driven 0 on reads (APB4 rule). pwdata holds its last value on reads.
- paddr, pwrite, pwdata, pstrb and pprot are stable from SETUP through the final ACCESS cycle.
- err_count increments by 1 on entry to RESP with a non-OKAY code and saturates at 16'hFFFF.

## Timing
- Reset values:
  - req_ready=0 during reset and 1 in the first cycle after reset;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0;
  - psel=0, penable=0, paddr/pwdata/pstrb/pprot/pwrite all 0.
- Request handshake at edge N gives SETUP in cycle N+1 and ACCESS from N+2.
  - Zero-wait slave (pready=1 in the first ACCESS cycle): rsp_valid in cycle N+3.
  - Each wait state adds 1 cycle.
- psel and penable deassert in the cycle after pready is sampled; there is no idle gap bubble inside a transfer.
- DECERR: rsp_valid in cycle N+1, with no psel activity.
- Timeout: the abort fires after exactly TIMEOUT_CYCLES ACCESS cycles. psel/penable drop the next cycle. A pready arriving in the same cycle the timeout fires wins (normal completion).
- Minimum spacing between transfers: 4 cycles when rsp_ready is held high. The next req_ready comes in the cycle after the RESP handshake.
- Reset asserted mid-transfer: at the next edge all outputs return to reset values, and the pending response is discarded.
- pready or pslverr from unselected slaves is ignored.

## Structure
- Package apb_master_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - rsp_err enum (OKAY, SLVERR, TIMEOUT, DECERR);
  - width constant ERR_CNT_W=16.
- Sub-module apb_addr_decode (combinational): address to index, one-hot psel vector and decode-error flag.
- Timeout counter is inline, with width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- **Zero-wait write:** write 0x0000_1004 ← 0xDEAD_BEEF to a slave with pready=1. Required: psel[1] in SETUP, penable in the next cycle, rsp OKAY 3 cycles after the handshake, pstrb=0xF.
- **Wait-state read:** read 0x0000_2000 with pready delayed 3 cycles and slave-2 prdata=0x1234_5678. Required: rdata=0x1234_5678, rsp after 6 cycles, pstrb=0.
- **SLVERR:** read with pslverr=1 at pready. Required: rsp_err=01, rdata=0, err_count=1.
- **Timeout and DECERR:**
  - With TIMEOUT_CYCLES=8 and pready held 0: TIMEOUT after 8 ACCESS cycles, psel dropped.
  - With NUM_SLAVES=3, address index 3: DECERR next cycle, no psel.
- **Backpressure and reset:**
  - rsp_ready held 0 for 5 cycles: rsp stable and req_ready=0 throughout.
  - reset asserted during ACCESS: psel, penable and rsp_valid all 0 at the next edge.
